// File: rtl/lane_endpoint.sv
// Node-side endpoint for one router lane: TX FIFO feeding the lane write side, RX FSM draining the read side.
// Optional per-direction flit counters are enabled with `define LANE_ENDPOINT_STATS_EN.
module lane_endpoint #(
  parameter int DATA  = 64,
  parameter int DEPTH = 2
) (
  input  logic            clK,
  input  logic            rsT,
  input  logic            tx_valid,
  input  logic [DATA-1:0] tx_data,
  output logic            tx_ready,
  output logic            rx_valid,
  output logic [DATA-1:0] rx_data,
  input  logic            rx_ready,
  output logic            WR,
  output logic [DATA-1:0] IN,
  input  logic            in_BUSY,
  output logic            RD,
  input  logic [DATA-1:0] OUT,
  input  logic            out_BUSY
`ifdef LANE_ENDPOINT_STATS_EN
  ,
  output logic [31:0]     tx_count,
  output logic [31:0]     rx_count
`endif
);

  localparam int ENTRIES = 1 << DEPTH;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_CAP, S_HOLD} rx_state_t;

  logic [DATA-1:0] r_mem [ENTRIES];
  logic [DEPTH:0]  r_wptr;
  logic [DEPTH:0]  r_rptr;
  logic            w_full;
  logic            w_empty;
  logic            w_push;
  logic            w_pop;

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign w_empty  = (r_wptr == r_rptr);
  assign w_full   = (r_wptr[DEPTH] != r_rptr[DEPTH]) &&
                    (r_wptr[DEPTH-1:0] == r_rptr[DEPTH-1:0]);
  assign tx_ready = !w_full;
  assign w_push   = tx_valid && !w_full;
  assign w_pop    = !w_empty && !in_BUSY;
  assign WR       = w_pop;
  assign IN       = w_empty ? '0 : r_mem[r_rptr[DEPTH-1:0]];

  always_ff @(posedge clK or negedge rsT) begin
    if (!rsT) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + {{DEPTH{1'b0}}, 1'b1};
      if (w_pop)  r_rptr <= r_rptr + {{DEPTH{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clK) begin
    if (w_push) r_mem[r_wptr[DEPTH-1:0]] <= tx_data;
  end

  rx_state_t       r_state;
  rx_state_t       w_state_nxt;
  logic [DATA-1:0] r_rx_data;

  always_ff @(posedge clK or negedge rsT) begin
    if (!rsT) begin
      r_state   <= S_IDLE;
      r_rx_data <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_CAP) r_rx_data <= OUT;
    end
  end

  // Single outstanding read: a new request is only possible once HOLD is released.
  always_comb begin
    w_state_nxt = r_state;
    RD          = 1'b0;
    rx_valid    = 1'b0;
    case (r_state)
      S_IDLE: if (out_BUSY) w_state_nxt = S_REQ;
      S_REQ: begin
        RD          = 1'b1;
        w_state_nxt = S_CAP;
      end
      S_CAP:  w_state_nxt = S_HOLD;
      S_HOLD: begin
        rx_valid = 1'b1;
        if (rx_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign rx_data = r_rx_data;

`ifdef LANE_ENDPOINT_STATS_EN
  logic [31:0] r_tx_count;
  logic [31:0] r_rx_count;

  always_ff @(posedge clK or negedge rsT) begin
    if (!rsT) begin
      r_tx_count <= '0;
      r_rx_count <= '0;
    end else begin
      if (WR)                  r_tx_count <= r_tx_count + 32'd1;
      if (rx_valid && rx_ready) r_rx_count <= r_rx_count + 32'd1;
    end
  end

  assign tx_count = r_tx_count;
  assign rx_count = r_rx_count;
`endif

endmodule

// File: tb/tb_lane_endpoint.sv
// Directed bench for lane_endpoint with TX/RX scoreboard queues checked by negedge monitors.
module tb_lane_endpoint;
  localparam int DATA  = 64;
  localparam int DEPTH = 2;

  logic            clK = 1'b0;
  logic            rsT;
  logic            tx_valid;
  logic [DATA-1:0] tx_data;
  logic            tx_ready;
  logic            rx_valid;
  logic [DATA-1:0] rx_data;
  logic            rx_ready;
  logic            WR;
  logic [DATA-1:0] IN;
  logic            in_BUSY;
  logic            RD;
  logic [DATA-1:0] OUT;
  logic            out_BUSY;
`ifdef LANE_ENDPOINT_STATS_EN
  logic [31:0]     tx_count;
  logic [31:0]     rx_count;
`endif

  int n_cmp = 0;
  int n_mis = 0;
  logic [DATA-1:0] txq[$];
  logic [DATA-1:0] rxq[$];
  logic            exp_wr;
  logic [3:0]      busy_pat;

  lane_endpoint #(.DATA(DATA), .DEPTH(DEPTH)) dut (
    .clK(clK), .rsT(rsT),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .WR(WR), .IN(IN), .in_BUSY(in_BUSY),
    .RD(RD), .OUT(OUT), .out_BUSY(out_BUSY)
`ifdef LANE_ENDPOINT_STATS_EN
    , .tx_count(tx_count), .rx_count(rx_count)
`endif
  );

  always #5 clK = ~clK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clK);
    #1;
  endtask

  task automatic smp();
    @(negedge clK);
  endtask

  // Scoreboard monitors: every WR must carry the oldest pushed flit, every accept the oldest expected RX flit.
  always @(negedge clK) begin
    if (rsT === 1'b1) begin
      if (WR === 1'b1) begin
        if (txq.size() == 0) chk("tx_unexpected_wr", WR, 0);
        else                 chk("tx_in_order", IN, txq.pop_front());
      end
      if (rx_valid === 1'b1 && rx_ready === 1'b1) begin
        if (rxq.size() == 0) chk("rx_unexpected_accept", rx_valid, 0);
        else                 chk("rx_data_accept", rx_data, rxq.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rsT = 1'b0; tx_valid = 1'b0; tx_data = '0; rx_ready = 1'b0;
    in_BUSY = 1'b0; OUT = '0; out_BUSY = 1'b0;
    repeat (2) @(posedge clK);
    #1 rsT = 1'b1;

    // Reset release, idle
    for (int c = 0; c < 3; c++) begin
      smp();
      chk("rst_tx_ready", tx_ready, 1);
      chk("rst_wr", WR, 0);
      chk("rst_rd", RD, 0);
      chk("rst_rx_valid", rx_valid, 0);
      chk("rst_rx_data", rx_data, 0);
      chk("rst_in", IN, 0);
      nxt();
    end

    // Fill FIFO while lane busy, overflow push ignored, then drain
    in_BUSY = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tx_valid = 1'b1;
      tx_data  = 64'hA1 + 64'(i);
      txq.push_back(tx_data);
      smp();
      chk("fill_tx_ready", tx_ready, 1);
      chk("fill_wr_busy", WR, 0);
      nxt();
    end
    tx_data = 64'hA5;
    smp();
    chk("full_tx_ready", tx_ready, 0);
    nxt();
    tx_valid = 1'b0;
    in_BUSY  = 1'b0;
    for (int k = 0; k < 4; k++) begin
      smp();
      chk("drain_wr", WR, 1);
      chk("drain_tx_ready", tx_ready, (k == 0) ? 1'b0 : 1'b1);
      nxt();
    end
    smp();
    chk("drain_done_wr", WR, 0);
    chk("drain_done_in", IN, 0);
    chk("drain_txq_empty", txq.size(), 0);
    nxt();

    // in_BUSY toggling with two flits queued
    in_BUSY = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tx_valid = 1'b1;
      tx_data  = 64'h10 + 64'(i);
      txq.push_back(tx_data);
      nxt();
    end
    tx_valid = 1'b0;
    busy_pat = 4'b0101;
    for (int k = 0; k < 4; k++) begin
      in_BUSY = busy_pat[k];
      exp_wr  = (txq.size() != 0) && !in_BUSY;
      smp();
      chk("toggle_wr", WR, exp_wr);
      nxt();
    end
    in_BUSY = 1'b0;
    smp();
    chk("toggle_wr_empty", WR, 0);
    chk("toggle_txq_empty", txq.size(), 0);
    nxt();

    // RX single read with backpressure
    out_BUSY = 1'b1; rx_ready = 1'b0; OUT = '0;
    smp(); chk("rx_idle_rd", RD, 0); chk("rx_idle_valid", rx_valid, 0);
    nxt();
    OUT = 64'hDEAD;
    smp(); chk("rx_req_rd", RD, 1);
    nxt();
    OUT = 64'hBEEF;
    rxq.push_back(64'hBEEF);
    smp(); chk("rx_cap_rd", RD, 0); chk("rx_cap_valid", rx_valid, 0);
    nxt();
    OUT = 64'h5555;
    for (int k = 0; k < 5; k++) begin
      smp();
      chk("rx_hold_valid", rx_valid, 1);
      chk("rx_hold_data", rx_data, 64'hBEEF);
      chk("rx_hold_rd", RD, 0);
      nxt();
    end
    rx_ready = 1'b1;
    smp(); chk("rx_accept_valid", rx_valid, 1);
    nxt();
    rx_ready = 1'b0;
    smp(); chk("rx_back_idle_valid", rx_valid, 0); chk("rx_back_idle_rd", RD, 0);
    nxt();
    out_BUSY = 1'b0;
    smp(); chk("rx_second_rd", RD, 1);
    nxt();
    OUT = 64'h1234;
    rxq.push_back(64'h1234);
    smp(); chk("rx2_cap_valid", rx_valid, 0);
    nxt();
    rx_ready = 1'b1;
    smp(); chk("rx2_hold_valid", rx_valid, 1);
    nxt();
    rx_ready = 1'b0;
    smp();
    chk("rx2_done_valid", rx_valid, 0);
    chk("rx2_done_rd", RD, 0);
    chk("rxq_empty", rxq.size(), 0);
    nxt();

    // Asynchronous reset while in REQ with two flits queued
    in_BUSY = 1'b1; tx_valid = 1'b1; tx_data = 64'h20; txq.push_back(tx_data);
    nxt();
    tx_data = 64'h21; txq.push_back(tx_data); out_BUSY = 1'b1;
    smp(); chk("ar_pre_rd", RD, 0);
    nxt();
    tx_valid = 1'b0; out_BUSY = 1'b0;
    smp();
    chk("ar_req_rd", RD, 1);
    chk("ar_busy_wr", WR, 0);
    #1 in_BUSY = 1'b0;
    #1 chk("ar_wr_live", WR, 1);
    rsT = 1'b0;
    #1;
    chk("ar_rd_drop", RD, 0);
    chk("ar_wr_drop", WR, 0);
    chk("ar_rx_valid", rx_valid, 0);
    chk("ar_tx_ready", tx_ready, 1);
    chk("ar_rx_data", rx_data, 0);
    chk("ar_in", IN, 0);
    txq.delete();
    nxt();
    rsT = 1'b1;
    out_BUSY = 1'b1;
    smp();
    chk("ar_post_tx_ready", tx_ready, 1);
    chk("ar_post_wr", WR, 0);
    chk("ar_post_rd", RD, 0);
    nxt();
    out_BUSY = 1'b0;
    smp(); chk("ar_idle_then_rd", RD, 1);
    nxt();
    OUT = 64'h77; rxq.push_back(64'h77); rx_ready = 1'b1;
    smp(); chk("ar_cap_valid", rx_valid, 0);
    nxt();
    smp(); chk("ar_hold_valid", rx_valid, 1);
    nxt();
    rx_ready = 1'b0;
    smp(); chk("ar_done_valid", rx_valid, 0);
    nxt();

`ifdef LANE_ENDPOINT_STATS_EN
    // Counters: 6 TX, 3 RX, then wrap from all-ones
    rsT = 1'b0;
    #2 rsT = 1'b1;
    smp();
    chk("st_tx_rst", tx_count, 0);
    chk("st_rx_rst", rx_count, 0);
    nxt();
    in_BUSY = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tx_valid = 1'b1; tx_data = 64'h300 + 64'(i); txq.push_back(tx_data);
      nxt();
    end
    tx_valid = 1'b0;
    for (int r = 0; r < 3; r++) begin
      out_BUSY = 1'b1; nxt();
      out_BUSY = 1'b0; nxt();
      OUT = 64'h400 + 64'(r); rxq.push_back(OUT); rx_ready = 1'b1; nxt();
      nxt();
      rx_ready = 1'b0;
    end
    nxt();
    smp();
    chk("st_tx_count", tx_count, 6);
    chk("st_rx_count", rx_count, 3);
    nxt();
    force dut.r_tx_count = 32'hFFFF_FFFF;
    force dut.r_rx_count = 32'hFFFF_FFFF;
    #1;
    release dut.r_tx_count;
    release dut.r_rx_count;
    tx_valid = 1'b1; tx_data = 64'h500; txq.push_back(tx_data); out_BUSY = 1'b1;
    nxt();
    tx_valid = 1'b0; out_BUSY = 1'b0;
    nxt();
    OUT = 64'h501; rxq.push_back(OUT); rx_ready = 1'b1;
    nxt();
    nxt();
    rx_ready = 1'b0;
    smp();
    chk("st_tx_wrap", tx_count, 0);
    chk("st_rx_wrap", rx_count, 0);
    nxt();
`endif

    smp();
    chk("final_txq_empty", txq.size(), 0);
    chk("final_rxq_empty", rxq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
